sseg_scan_ctrl: RTL and testbench

//  N-digit multiplexed seven-segment scan controller, successor to the 2-digit seven_seg_ctrl.

---
 rtl/sseg_scan_ctrl_pkg.sv | 21 ++
 rtl/sseg_scan_ctrl_hex.sv | 11 +
 rtl/sseg_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: hex glyph table,
// the all-dark segment pattern and the index-width helper.
package sseg_scan_ctrl_pkg;

  // Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // ceil(log2(n)), but never below 1 so a single-digit build still has an index bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_hex.sv
// Combinational hex nibble to seven-segment decode (active-high glyph).
module sseg_scan_ctrl_hex
  import sseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nib];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with PWM brightness, leading-zero
// suppression and a double-buffered load that only commits at frame boundaries.
module sseg_scan_ctrl
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int NDIGITS        = 2,
  parameter int DIV_BITS       = 10,
  parameter int BRIGHT_BITS    = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0,
  parameter int LZ_SUPPRESS    = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic [4*NDIGITS-1:0]     i_din,
  input  logic [NDIGITS-1:0]       i_dp_in,
  input  logic [NDIGITS-1:0]       i_blank_in,
  input  logic [BRIGHT_BITS-1:0]   i_brightness,
  output logic [6:0]               o_seg,
  output logic                     o_dp,
  output logic [NDIGITS-1:0]       o_dig_sel,
  output logic                     o_frame_done
);

  localparam int                 IDX_W    = clog2_min1(NDIGITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NDIGITS - 1);
  localparam logic [6:0]         SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic               DP_IDLE  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NDIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_BITS-1:0]    r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [4*NDIGITS-1:0]   r_pend_data;
  logic [NDIGITS-1:0]     r_pend_dp;
  logic [NDIGITS-1:0]     r_pend_blank;
  logic                   r_pend_valid;
  logic [4*NDIGITS-1:0]   r_act_data;
  logic [NDIGITS-1:0]     r_act_dp;
  logic [NDIGITS-1:0]     r_act_blank;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [NDIGITS-1:0]     r_dig_sel;
  logic                   r_frame_done;

  logic                   w_tick;
  logic                   w_wrap;
  logic [3:0]             w_nib;
  logic [6:0]             w_glyph;
  logic [BRIGHT_BITS-1:0] w_phase;
  logic                   w_pwm_on;
  logic                   w_dark;
  logic [6:0]             w_seg_lit;
  logic                   w_dp_lit;
  logic [NDIGITS-1:0]     w_dig_oh;
  logic [NDIGITS-1:0]     w_lz_mask;
  logic                   w_lead;

  assign w_tick = &r_cnt;
  assign w_wrap = w_tick && (r_idx == LAST_IDX);
  assign w_nib  = r_act_data[{r_idx, 2'b00} +: 4];

  sseg_scan_ctrl_hex u_hex (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_dig
      assign w_dig_oh[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Walk down from the top digit; zeros stay suppressed until a visible nonzero
  // digit is met. Digit 0 is never part of the walk.
  always_comb begin
    w_lz_mask = '0;
    w_lead    = 1'b1;
    for (int d = NDIGITS - 1; d >= 1; d--) begin
      if ((LZ_SUPPRESS != 0) && w_lead && (r_act_data[4*d +: 4] == 4'd0))
        w_lz_mask[d] = 1'b1;
      if (!r_act_blank[d] && (r_act_data[4*d +: 4] != 4'd0))
        w_lead = 1'b0;
    end
  end

  assign w_phase   = r_cnt[DIV_BITS-1 -: BRIGHT_BITS];
  assign w_pwm_on  = (&i_brightness) | (w_phase < i_brightness);
  assign w_dark    = r_act_blank[r_idx] | w_lz_mask[r_idx] | ~w_pwm_on;
  assign w_seg_lit = w_dark ? SEG_OFF : w_glyph;
  assign w_dp_lit  = ~w_dark & r_act_dp[r_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_seg        <= SEG_IDLE;
      r_dp         <= DP_IDLE;
      r_dig_sel    <= DIG_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_frame_done <= w_wrap;
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

      // A load landing on the boundary itself goes straight to the active copy.
      if (w_wrap) begin
        if (i_load) begin
          r_act_data  <= i_din;
          r_act_dp    <= i_dp_in;
          r_act_blank <= i_blank_in;
        end else if (r_pend_valid) begin
          r_act_data  <= r_pend_data;
          r_act_dp    <= r_pend_dp;
          r_act_blank <= r_pend_blank;
        end
        r_pend_valid <= 1'b0;
      end else if (i_load) begin
        r_pend_data  <= i_din;
        r_pend_dp    <= i_dp_in;
        r_pend_blank <= i_blank_in;
        r_pend_valid <= 1'b1;
      end

      r_seg     <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
      r_dp      <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_lit  : w_dp_lit;
      r_dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~w_dig_oh  : w_dig_oh;
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_dig_sel    = r_dig_sel;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: a 2-digit and a 4-digit (LZ, inverted polarities) instance
// driven together and compared every cycle against a slot-arithmetic display model.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  bl_in = '0;
  logic [1:0]  bright = 2'd3;

  logic [6:0] seg2, seg4;
  logic       dp2, dp4, fd2, fd4;
  logic [1:0] dig2;
  logic [3:0] dig4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.NDIGITS(2), .DIV_BITS(4), .BRIGHT_BITS(2),
                   .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0), .LZ_SUPPRESS(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_din(din[7:0]),
    .i_dp_in(dp_in[1:0]), .i_blank_in(bl_in[1:0]), .i_brightness(bright),
    .o_seg(seg2), .o_dp(dp2), .o_dig_sel(dig2), .o_frame_done(fd2));

  sseg_scan_ctrl #(.NDIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2),
                   .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_din(din),
    .i_dp_in(dp_in), .i_blank_in(bl_in), .i_brightness(bright),
    .o_seg(seg4), .o_dp(dp4), .o_dig_sel(dig4), .o_frame_done(fd4));

  // Model configuration per instance: digits, LZ, seg active-low, dig active-low.
  localparam int ND  [2] = '{2, 4};
  localparam int LZ  [2] = '{0, 1};
  localparam int SAL [2] = '{1, 0};
  localparam int DAL [2] = '{0, 1};

  int         t [2];
  logic [3:0] a_d [2][4];
  logic [3:0] p_d [2][4];
  logic       a_dp [2][4];
  logic       a_bl [2][4];
  logic       p_dp [2][4];
  logic       p_bl [2][4];
  bit         pv [2];
  logic [6:0] e_seg [2];
  logic       e_dp [2];
  logic [3:0] e_dig [2];
  logic       e_fd [2];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k]  = 0;
      pv[k] = 0;
      for (int j = 0; j < 4; j++) begin
        a_d[k][j] = 4'h0; a_dp[k][j] = 1'b0; a_bl[k][j] = 1'b1;
        p_d[k][j] = 4'h0; p_dp[k][j] = 1'b0; p_bl[k][j] = 1'b1;
      end
      e_seg[k] = (SAL[k] != 0) ? 7'h7F : 7'h00;
      e_dp[k]  = (SAL[k] != 0);
      e_dig[k] = (DAL[k] != 0) ? 4'hF : 4'h0;
      e_fd[k]  = 1'b0;
    end
  endtask

  // Predicts the outputs registered at the coming edge and applies load/commit rules.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n, cnt, slot;
      bit on, sup, lit, bnd;
      logic [6:0] segv;
      logic dpv;
      logic [3:0] oh;
      n    = ND[k];
      cnt  = t[k] % 16;
      slot = (t[k] / 16) % n;
      on   = (bright == 2'd3) || ((cnt / 4) < int'(bright));
      sup  = 0;
      if (LZ[k] != 0 && slot > 0) begin
        sup = 1;
        for (int j = slot; j < n; j++)
          if (!a_bl[k][j] && a_d[k][j] != 4'h0) sup = 0;
      end
      lit  = on && !a_bl[k][slot] && !sup;
      segv = lit ? glyph(a_d[k][slot]) : 7'h00;
      dpv  = lit && a_dp[k][slot];
      e_seg[k] = (SAL[k] != 0) ? ~segv : segv;
      e_dp[k]  = (SAL[k] != 0) ? !dpv : dpv;
      oh = 4'b0001 << slot;
      e_dig[k] = (DAL[k] != 0) ? ~oh : oh;
      bnd = (t[k] % (16 * n)) == (16 * n - 1);
      e_fd[k] = bnd;
      if (bnd) begin
        for (int j = 0; j < n; j++) begin
          if (load) begin
            a_d[k][j] = din[4*j +: 4]; a_dp[k][j] = dp_in[j]; a_bl[k][j] = bl_in[j];
          end else if (pv[k]) begin
            a_d[k][j] = p_d[k][j]; a_dp[k][j] = p_dp[k][j]; a_bl[k][j] = p_bl[k][j];
          end
        end
        pv[k] = 0;
      end else if (load) begin
        for (int j = 0; j < n; j++) begin
          p_d[k][j] = din[4*j +: 4]; p_dp[k][j] = dp_in[j]; p_bl[k][j] = bl_in[j];
        end
        pv[k] = 1;
      end
      t[k]++;
    end
  endtask

  task automatic check_all();
    check("seg2", 16'(seg2), 16'(e_seg[0]));
    check("dp2",  16'(dp2),  16'(e_dp[0]));
    check("dig2", 16'(dig2), 16'(e_dig[0]));
    check("fd2",  16'(fd2),  16'(e_fd[0]));
    check("seg4", 16'(seg4), 16'(e_seg[1]));
    check("dp4",  16'(dp4),  16'(e_dp[1]));
    check("dig4", 16'(dig4), 16'(e_dig[1]));
    check("fd4",  16'(fd4),  16'(e_fd[1]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    din = d; dp_in = dp; bl_in = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int lit_cnt;

    // Reset state
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    check("rst_seg2", 16'(seg2), 16'h007F);
    @(negedge clk);
    rst_n = 1'b1;

    // Dark display, digit scan running, for 10 frames of the 2-digit unit
    repeat (320) tick();

    // Load 3A with dp on digit 0, committed at the next frame
    do_load(16'h003A, 4'b0001, 4'b0000);
    repeat (64) tick();
    while (t[0] % 32 != 5) tick();
    check("t2_slot0_seg", 16'(seg2), 16'h0008);
    check("t2_slot0_dp", 16'(dp2), 16'h0000);
    repeat (16) tick();
    check("t2_slot1_seg", 16'(seg2), 16'h0030);
    check("t2_slot1_dp", 16'(dp2), 16'h0001);

    // Tearing: two loads in one frame, only the last appears next frame
    while (t[0] % 32 != 2) tick();
    do_load(16'h0012, 4'b0000, 4'b0000);
    while (t[0] % 32 != 12) tick();
    do_load(16'h0034, 4'b0000, 4'b0000);
    while (t[0] % 32 != 5) tick();
    check("t3_slot0_seg", 16'(seg2), 16'h0019);
    repeat (16) tick();
    check("t3_slot1_seg", 16'(seg2), 16'h0030);

    // Load coincident with the frame boundary
    while (t[0] % 32 != 31) tick();
    do_load(16'h00C7, 4'b0000, 4'b0000);
    while (t[0] % 32 != 5) tick();
    check("t3b_slot0_seg", 16'(seg2), 16'h0078);
    repeat (16) tick();
    check("t3b_slot1_seg", 16'(seg2), 16'h0046);

    // PWM duty over 16 consecutive cycles
    bright = 2'd1; lit_cnt = 0;
    repeat (16) begin tick(); if (seg2 != 7'h7F) lit_cnt++; end
    check("pwm_b1_lit", 16'(lit_cnt), 16'd4);
    bright = 2'd0; lit_cnt = 0;
    repeat (16) begin tick(); if (seg2 != 7'h7F) lit_cnt++; end
    check("pwm_b0_lit", 16'(lit_cnt), 16'd0);
    bright = 2'd3; lit_cnt = 0;
    repeat (16) begin tick(); if (seg2 != 7'h7F) lit_cnt++; end
    check("pwm_b3_lit", 16'(lit_cnt), 16'd16);

    // Leading-zero suppression on the 4-digit unit
    do_load(16'h0050, 4'b0000, 4'b0000);
    repeat (64) tick();
    while (t[1] % 64 != 5) tick();
    check("lz50_d0", 16'(seg4), 16'h003F);
    repeat (16) tick();
    check("lz50_d1", 16'(seg4), 16'h006D);
    repeat (16) tick();
    check("lz50_d2", 16'(seg4), 16'h0000);
    repeat (16) tick();
    check("lz50_d3", 16'(seg4), 16'h0000);
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (64) tick();
    while (t[1] % 64 != 5) tick();
    check("lz00_d0", 16'(seg4), 16'h003F);
    repeat (16) tick();
    check("lz00_d1", 16'(seg4), 16'h0000);

    // Randomized traffic, zero nibbles biased up to exercise suppression
    repeat (1500) begin
      for (int j = 0; j < 4; j++)
        din[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      dp_in  = 4'($urandom);
      bl_in  = 4'($urandom & $urandom);
      bright = 2'($urandom);
      load   = ($urandom_range(0, 15) == 0);
      tick();
    end
    load = 1'b0; bright = 2'd3;

    // Asynchronous reset mid-slot with a pending load
    while (t[0] % 32 != 8) tick();
    do_load(16'hBEEF, 4'b1111, 4'b0000);
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_async_seg4", 16'(seg4), 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_idx0_dig2", 16'(dig2), 16'h0001);
    lit_cnt = 0;
    repeat (96) begin tick(); if (seg2 != 7'h7F) lit_cnt++; end
    check("rst_dark_lit", 16'(lit_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
